// File: rtl/lcd_bus_if.sv
// Request handshake and HD44780-style LCD pin bundle between the core and lcd_bus_driver.
// Signal names keep the driver's point of view (i_* into the driver, o_* out of it).
interface lcd_bus_if;
   logic        i_lcd_on;
   logic        i_valid;
   logic        i_rs;
   logic [7:0]  i_data;
   logic        o_ready;
   logic        o_busy;
   logic [7:0]  o_lcd_data;
   logic        o_lcd_rs;
   logic        o_lcd_rw;
   logic        o_lcd_en;
   logic        o_lcd_on;
   logic [31:0] o_io_lcd;

   modport master (
      output i_lcd_on, i_valid, i_rs, i_data,
      input  o_ready, o_busy, o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_io_lcd
   );

   modport slave (
      input  i_lcd_on, i_valid, i_rs, i_data,
      output o_ready, o_busy, o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_io_lcd
   );
endinterface

// File: rtl/lcd_bus_driver.sv
// Timing engine for an HD44780-style character LCD: one byte per valid/ready handshake,
// driven with setup, enable pulse, hold and execution wait; every output is a flop.
module lcd_bus_driver #(
   parameter int SETUP_CYC      = 2,
   parameter int EN_HIGH_CYC    = 12,
   parameter int HOLD_CYC       = 2,
   parameter int EXEC_CYC       = 2000,
   parameter int CLEAR_EXEC_CYC = 82000,
   parameter int POWERUP_CYC    = 750000
) (
   input  logic     i_clk,
   input  logic     i_rst,
   lcd_bus_if.slave bus
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                 max2(CLEAR_EXEC_CYC, POWERUP_CYC));
   localparam int CW = $clog2(MAX_CYC) + 1;

   // Each timed state loads N-1 and leaves on the cycle the counter reads zero.
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] ENH_LD   = CW'(EN_HIGH_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
   localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_EXEC_CYC - 1);
   localparam logic [CW-1:0] PWRUP_LD = CW'(POWERUP_CYC - 1);

   typedef enum logic [2:0] {
      PWRUP = 3'd0,
      IDLE  = 3'd1,
      SETUP = 3'd2,
      ENH   = 3'd3,
      HOLD  = 3'd4,
      EXEC  = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;
   logic          cnt_zero;
   logic          long_exec;

   logic          ready_q, ready_d;
   logic          busy_q;
   logic          en_q, en_d;
   logic [7:0]    data_q, data_d;
   logic          rs_q, rs_d;
   logic          on_q;

   assign cnt_zero = (cnt_q == '0);
   // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
   assign long_exec = ~rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         PWRUP: begin
            if (cnt_zero) state_d = IDLE;
            else          cnt_d   = cnt_q - 1'b1;
         end
         IDLE: begin
            if (bus.i_valid) begin
               accept  = 1'b1;
               state_d = SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt_zero) begin
               state_d = ENH;
               cnt_d   = ENH_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ENH: begin
            if (cnt_zero) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               state_d = EXEC;
               cnt_d   = long_exec ? CLEAR_LD : EXEC_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         EXEC: begin
            if (cnt_zero) state_d = IDLE;
            else          cnt_d   = cnt_q - 1'b1;
         end
         default: begin
            state_d = PWRUP;
            cnt_d   = PWRUP_LD;
         end
      endcase
   end

   // Output logic, decoded from the next state so the pins come straight from flops
   always_comb begin
      ready_d = (state_d == IDLE);
      en_d    = (state_d == ENH);
      data_d  = data_q;
      rs_d    = rs_q;
      if (accept) begin
         data_d = bus.i_data;
         rs_d   = bus.i_rs;
      end
   end

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= PWRUP;
         cnt_q   <= PWRUP_LD;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         en_q    <= 1'b0;
         data_q  <= 8'd0;
         rs_q    <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         busy_q  <= ~ready_d;
         en_q    <= en_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         on_q    <= bus.i_lcd_on;
      end
   end

   assign bus.o_ready    = ready_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_lcd_data = data_q;
   assign bus.o_lcd_rs   = rs_q;
   assign bus.o_lcd_rw   = 1'b0;
   assign bus.o_lcd_en   = en_q;
   assign bus.o_lcd_on   = on_q;
   assign bus.o_io_lcd   = {on_q, 20'd0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Randomised bench for lcd_bus_driver: a transfer-level timeline model predicts every pin
// each cycle, and a scoreboard matches each enable pulse against the accepted transfers.
module tb_lcd_bus_driver;

   localparam int S  = 2;
   localparam int E  = 4;
   localparam int H  = 2;
   localparam int X  = 10;
   localparam int XC = 40;
   localparam int P  = 20;

   typedef struct {
      int       t;
      bit       rs;
      bit [7:0] data;
   } xfer_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   lcd_bus_if bus();

   lcd_bus_driver #(
      .SETUP_CYC(S), .EN_HIGH_CYC(E), .HOLD_CYC(H),
      .EXEC_CYC(X), .CLEAR_EXEC_CYC(XC), .POWERUP_CYC(P)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int       checks = 0;
   int       passes = 0;
   int       cyc = 0;
   bit       model_live = 0;
   int       ready_at = 0;
   int       en_lo = -100;
   int       en_hi = -100;
   bit       cur_rs = 0;
   bit [7:0] cur_data = 8'd0;
   bit       on_exp = 0;
   int       rst_cnt = 0;
   int       xfer_cnt = 0;
   bit       toggle_on = 0;
   xfer_t    exp_q[$];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Reference timeline: a transfer accepted at edge T shows EN during [T+S, T+S+E)
   // and ready again from T+S+E+H+wait; reset restarts a P-cycle power-up.
   always @(posedge clk) begin
      int    w;
      xfer_t x;
      cyc++;
      if (rst) begin
         model_live = 1;
         ready_at   = cyc + P;
         en_lo      = -100;
         en_hi      = -100;
         cur_rs     = 0;
         cur_data   = 8'd0;
         on_exp     = 0;
         exp_q.delete();
         rst_cnt++;
      end else begin
         on_exp = bus.i_lcd_on;
         if (model_live && bus.i_valid === 1'b1 && (cyc - 1) >= ready_at) begin
            w        = (!bus.i_rs && (bus.i_data == 8'h01 || bus.i_data == 8'h02 || bus.i_data == 8'h03)) ? XC : X;
            cur_rs   = bus.i_rs;
            cur_data = bus.i_data;
            en_lo    = cyc + S;
            en_hi    = cyc + S + E;
            ready_at = cyc + S + E + H + w;
            x.t = cyc; x.rs = cur_rs; x.data = cur_data;
            exp_q.push_back(x);
            xfer_cnt++;
            $display("xfer %0d: cycle %0d rs=%0d data=0x%02h wait=%0d", xfer_cnt, cyc, cur_rs, cur_data, w);
         end
      end
   end

   // Per-cycle pin check against the timeline
   always @(negedge clk) begin
      bit e_en, e_rdy;
      if (model_live) begin
         e_en  = (cyc >= en_lo) && (cyc < en_hi);
         e_rdy = (cyc >= ready_at);
         chk("ready", 64'(bus.o_ready), 64'(e_rdy));
         chk("busy", 64'(bus.o_busy), 64'(!e_rdy));
         chk("io_lcd", 64'(bus.o_io_lcd), 64'({on_exp, 20'd0, e_en, cur_rs, 1'b0, cur_data}));
         chk("bus_pins", 64'({bus.o_lcd_on, bus.o_lcd_en, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_data}),
             64'({on_exp, e_en, cur_rs, 1'b0, cur_data}));
      end
   end

   // Scoreboard monitor: every EN pulse must belong to the oldest accepted transfer
   bit    en_prev = 0;
   bit    in_pulse = 0;
   int    rise_cyc = 0;
   int    rise_rst = 0;
   always @(negedge clk) begin
      xfer_t x;
      if (model_live) begin
         if (bus.o_lcd_en === 1'b1 && !en_prev) begin
            rise_cyc = cyc;
            rise_rst = rst_cnt;
            chk("pulse_has_xfer", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               x = exp_q.pop_front();
               chk("en_rise_cycle", 64'(cyc - x.t), 64'(S));
               chk("en_payload", 64'({bus.o_lcd_rs, bus.o_lcd_data}), 64'({x.rs, x.data}));
               in_pulse = 1;
            end
         end
         if (bus.o_lcd_en !== 1'b1 && en_prev && in_pulse) begin
            if (rst_cnt == rise_rst) chk("en_width", 64'(cyc - rise_cyc), 64'(E));
            in_pulse = 0;
         end
      end
      en_prev = (bus.o_lcd_en === 1'b1);
   end

   // Random display-power toggling, independent of transfers
   always @(negedge clk) begin
      if (toggle_on && $urandom_range(0, 5) == 0) bus.i_lcd_on = ~bus.i_lcd_on;
   end

   task automatic wait_ready(input bit garbage);
      int n = 0;
      while (bus.o_ready !== 1'b1 && n < 400) begin
         if (garbage) begin
            bus.i_valid = 1'b1;
            bus.i_rs    = 1'($urandom);
            bus.i_data  = 8'($urandom);
         end else begin
            bus.i_valid = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      chk("ready_within_bound", 64'(bus.o_ready === 1'b1), 64'(1));
   endtask

   task automatic send(input bit rs, input bit [7:0] d, input bit garbage);
      wait_ready(garbage);
      bus.i_valid = 1'b1;
      bus.i_rs    = rs;
      bus.i_data  = d;
      @(negedge clk);
      if (garbage) begin
         bus.i_rs   = 1'($urandom);
         bus.i_data = 8'($urandom);
      end else begin
         bus.i_valid = 1'b0;
      end
   endtask

   initial begin
      int n;
      bit [7:0] d;
      bus.i_lcd_on = 1'b0;
      bus.i_valid  = 1'b1;
      bus.i_rs     = 1'b1;
      bus.i_data   = 8'hA5;

      // Power-up with valid asserted throughout reset and the wait
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      send(1'b1, 8'h41, 1'b1);
      bus.i_valid = 1'b0;

      // Directed long/short execution cases
      send(1'b0, 8'h01, 1'b0);
      send(1'b0, 8'h38, 1'b0);
      send(1'b1, 8'h01, 1'b0);
      send(1'b0, 8'h02, 1'b0);
      send(1'b0, 8'h03, 1'b0);
      send(1'b0, 8'h04, 1'b0);
      send(1'b0, 8'h00, 1'b0);

      // Display power toggled while a transfer is in flight
      send(1'b1, 8'h42, 1'b0);
      repeat (4) @(negedge clk);
      bus.i_lcd_on = 1'b1;
      repeat (3) @(negedge clk);
      bus.i_lcd_on = 1'b0;

      // Back-to-back with valid held high and changing data while busy
      for (int i = 0; i < 4; i++) send(1'($urandom), 8'($urandom), 1'b1);

      // Reset during the second enable-high cycle
      send(1'b1, 8'h5A, 1'b0);
      n = 0;
      while (bus.o_lcd_en !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("en_seen_before_reset", 64'(bus.o_lcd_en === 1'b1), 64'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(1'b1, 8'h30, 1'b0);

      // Randomised traffic
      toggle_on = 1;
      for (int i = 0; i < 40; i++) begin
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         send(1'($urandom), d, 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            bus.i_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      toggle_on = 0;
      bus.i_valid = 1'b0;
      wait_ready(1'b0);
      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
